// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to build the WAIT-state watchdog (aborts after TIMEOUT_CYCLES).
module uart_tx_arbiter #(
  parameter int DATA_BITS      = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_done_tick,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int              PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, winner_q, win_idx;
  logic [NUM_REQ-1:0]     grant_q;
  logic [DATA_BITS-1:0]   tx_data_q;
  logic [DATA_BITS-1:0]   req_words [NUM_REQ];
  logic                   win_found;
  logic                   leave_wait;
  logic                   timeout_hit;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_words[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Search from ptr upward with wrap; the first pending requester wins.
  // NOTE: cand is a blocking temporary and every comb output is defaulted first, so no latch is inferred.
  always_comb begin
    logic [PTR_W:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q;

  // Cleared during START so the first WAIT cycle sees zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (state_q == START) begin
      wd_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // A completion tick in the expiry cycle wins over the abort.
  assign timeout_hit = (state_q == WAIT) && (wd_cnt_q == CNT_LAST) && !tx_done_tick;
`else
  assign timeout_hit = 1'b0;
`endif

  assign leave_wait = (state_q == WAIT) && (tx_done_tick || timeout_hit);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (leave_wait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    req_ack  = '0;
    busy     = 1'b0;
    case (state_q)
      START: begin
        tx_start = 1'b1;
        req_ack  = grant_q;
        busy     = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: ;
    endcase
  end

  // Word and owner are captured on the IDLE->START edge and frozen until WAIT ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      winner_q  <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
    end else begin
      if (state_q == IDLE && win_found) begin
        winner_q  <= win_idx;
        grant_q   <= NUM_REQ'(1) << win_idx;
        tx_data_q <= req_words[win_idx];
      end
      if (leave_wait) begin
        grant_q <= '0;
        ptr_q   <= (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8, TIMEOUT_CYCLES=50).
// Exercises the watchdog when UART_TX_ARB_TIMEOUT_EN is defined, its absence otherwise.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(
    .DATA_BITS     (8),
    .NUM_REQ       (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [7:0] val);
    req_data[idx*8 +: 8] = val;
  endtask

  initial begin
    int cnt;
    int err_seen;
    logic [7:0] exp_data [5];
    logic [3:0] exp_ack  [5];
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    tx_done_tick = 1'b0;
    #2;
    check("rst_grant", grant, 4'b0000);
    check("rst_ack", req_ack, 4'b0000);
    check("rst_start", tx_start, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Single request from requester 2
    req = 4'b0100;
    set_word(2, 8'hA5);
    tick();
    check("single_start", tx_start, 1'b1);
    check("single_ack", req_ack, 4'b0100);
    check("single_data", tx_data, 8'hA5);
    check("single_grant", grant, 4'b0100);
    check("single_busy", busy, 1'b1);
    req = 4'b0000;
    tick();
    check("single_wait_start", tx_start, 1'b0);
    check("single_wait_ack", req_ack, 4'b0000);
    check("single_wait_grant", grant, 4'b0100);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check("single_done_grant", grant, 4'b0000);
    check("single_done_busy", busy, 1'b0);

    // Stability: ptr is 3, so requester 0 wins after wrap; data change in WAIT is ignored
    req = 4'b0001;
    set_word(0, 8'h3C);
    tick();
    check("stab_grant", grant, 4'b0001);
    check("stab_data0", tx_data, 8'h3C);
    set_word(0, 8'hFF);
    tick();
    tick();
    tick();
    check("stab_data_wait", tx_data, 8'h3C);
    check("stab_busy_wait", busy, 1'b1);
    req = 4'b0000;
    tx_done_tick = 1'b1;
    tick();
    check("stab_done_busy", busy, 1'b0);
    tick();
    tx_done_tick = 1'b0;
    check("spur_busy", busy, 1'b0);
    check("spur_start", tx_start, 1'b0);
    check("spur_grant", grant, 4'b0000);
    check("spur_data_hold", tx_data, 8'h3C);

    // Tick coincident with START is ignored; ptr is 1 so requester 1 wins
    req = 4'b0010;
    set_word(1, 8'h77);
    tick();
    check("startick_start", tx_start, 1'b1);
    check("startick_grant", grant, 4'b0010);
    req = 4'b0000;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check("startick_busy", busy, 1'b1);
    check("startick_grant_wait", grant, 4'b0010);
    tick();
    check("startick_busy2", busy, 1'b1);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check("startick_done", busy, 1'b0);

    // Reset five cycles after tx_start; ptr is 2 so requester 3 wins first
    req = 4'b1000;
    set_word(3, 8'h5A);
    tick();
    check("rmid_start", tx_start, 1'b1);
    check("rmid_grant", grant, 4'b1000);
    req = 4'b0000;
    repeat (5) tick();
    check("rmid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rmid_grant_rst", grant, 4'b0000);
    check("rmid_ack_rst", req_ack, 4'b0000);
    check("rmid_start_rst", tx_start, 1'b0);
    check("rmid_data_rst", tx_data, 8'h00);
    check("rmid_busy_rst", busy, 1'b0);
    check("rmid_terr_rst", timeout_err, 1'b0);
    tick();
    reset = 1'b0;
    req = 4'b1001;
    set_word(0, 8'h11);
    set_word(3, 8'h33);
    tick();
    check("rmid_after_grant", grant, 4'b0001);
    check("rmid_after_ack", req_ack, 4'b0001);
    check("rmid_after_data", tx_data, 8'h11);
    req = 4'b0000;
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;

    // Fairness from a fresh pointer: all four held, done 20 cycles after each start
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("fair_data_%0d", k), tx_data, exp_data[k]);
      check($sformatf("fair_ack_%0d", k), req_ack, exp_ack[k]);
      repeat (19) tick();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      if (k == 4) req = 4'b0000;
    end
    check("fair_idle", busy, 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: ptr is 1, requester 0 is the only one pending
    req = 4'b0001;
    tick();
    check("to_grant", grant, 4'b0001);
    req = 4'b0000;
    cnt = 0;
    err_seen = 0;
    while (cnt < 100 && err_seen == 0) begin
      tick();
      cnt++;
      if (timeout_err === 1'b1) err_seen = 1;
    end
    check("to_pulse_seen", err_seen, 1);
    check("to_pulse_cycle", cnt, 50);
    tick();
    check("to_pulse_width", timeout_err, 1'b0);
    check("to_idle", busy, 1'b0);
    check("to_grant_clr", grant, 4'b0000);
    req = 4'b0011;
    tick();
    check("to_next_grant", grant, 4'b0010);
    req = 4'b0000;
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
`else
    // No watchdog: WAIT persists without a completion tick
    req = 4'b0001;
    tick();
    check("nto_grant", grant, 4'b0001);
    req = 4'b0000;
    err_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (timeout_err !== 1'b0) err_seen++;
    end
    check("nto_terr", err_seen, 0);
    check("nto_busy", busy, 1'b1);
    check("nto_grant_hold", grant, 4'b0001);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check("nto_done", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
